if_fetch_icache: RTL and testbench
==================================

Name: if_fetch_icache

Overview:
- Instruction-fetch stage with a direct-mapped instruction cache, directly upstream of the memory controller's IF port.
- Holds the PC and serves cache hits in one cycle.
- On a miss, issues a word fetch to the memory controller, fills the cache line, then forwards the instruction to decode.
- Accepts stall and redirect (branch/jump) from the back end.

Parameters:
INDEX_WIDTH, 8, cache index bits; 2^INDEX_WIDTH one-word lines; tag = pc[31:INDEX_WIDTH+2]
RESET_PC, 32'h0, PC value loaded at reset

Ports:
clk_in  input  1  clock
rst_in  input  1  reset; synchronous, active-low (0 = reset), sampled on posedge clk_in
rdy_in  input  1  global ready; 0 freezes all state, outputs hold
stall_in  input  1  back end cannot accept an instruction this cycle
jump_flag  input  1  redirect request
jump_pc  input  32  redirect target; bits [1:0] ignored, forced 0
if_read_or_not  output  1  fetch request to memory controller
intru_addr  output  32  fetch word address to memory controller
if_load_done  input  1  memory controller fetch complete
mem_ctrl_instru_to_if  input  32  fetched instruction word, valid with if_load_done
inst_valid  output  1  one-cycle pulse: inst/inst_pc valid
inst  output  32  instruction to decode
inst_pc  output  32  PC of inst

Behaviour:
- Reset (rst_in=0 at posedge):
  - pc=RESET_PC; state=FETCH; discard=0.
  - All valid bits cleared.
  - if_read_or_not=0, intru_addr=0, inst_valid=0, inst=0, inst_pc=0.
- rdy_in=0: no register changes, including valid bits and state.
- States: FETCH, REQ, WAIT.
- FETCH:
  - hit = valid[pc idx] && tag match.
  - Priority 1, jump_flag=1: pc<=jump_pc; inst_valid<=0; stay in FETCH.
  - Priority 2, stall_in=1: inst_valid<=0; hold pc.
  - Priority 3, hit: inst<=line data; inst_pc<=pc; inst_valid<=1; pc<=pc+4 (32-bit wrap). Latency is one cycle from PC to registered output; back-to-back hits give one instruction per cycle.
  - Priority 4, miss: if_read_or_not<=1; intru_addr<=pc; inst_valid<=0; go to REQ.
- REQ (first request cycle):
  - Keep the request asserted and intru_addr stable.
  - Ignore if_load_done: it may be stale-high from the previous transfer.
  - Go to WAIT.
- WAIT:
  - Keep if_read_or_not=1 and intru_addr unchanged until if_load_done=1, however long the memory controller serves data accesses first.
  - On if_load_done=1:
    - Write mem_ctrl_instru_to_if into the line with tag; set valid.
    - Deassert if_read_or_not.
    - If discard=0: present the word (inst_valid<=1, inst_pc<=intru_addr, pc<=intru_addr+4).
    - If discard=1: no output, and pc is left at the redirect target.
    - Clear discard; go to FETCH.
- Redirect during REQ or WAIT:
  - pc<=jump_pc; discard<=1.
  - Request stays stable and the transfer completes, so the fill is still written.
  - A later redirect before completion overwrites pc again.
- Redirect on the same cycle as if_load_done in WAIT: line is filled, no output, pc<=jump_pc.
- stall_in=1 while a miss completes: word is presented anyway; the back end treats stall as affecting only the next issue.
- Only the FETCH path checks stall_in; a pending fill is never dropped.
- inst_valid is never high two cycles for the same PC.
- Cache is read-only; no self-modifying-code coherence is required.

Test Plan:
- Reset with RESET_PC=0; cold miss at 0 -> if_read_or_not=1 and intru_addr=0 held; memory controller returns 32'h00500093 with if_load_done -> next cycle inst_valid=1, inst=32'h00500093, inst_pc=0; pc=4; new request for 4.
- Loop back to 0 after fill -> hit, inst_valid on the cycle after pc=0, no request; 4 sequential hits give 4 consecutive inst_valid pulses, PCs 0,4,8,12.
- if_load_done held high (stale) on the first REQ cycle -> ignored; completion is taken only from a later pulse; inst matches the later data.
- Redirect jump_pc=32'h100 in WAIT for addr 0x20 -> no inst_valid for 0x20; line 0x20 filled (later hit, no request); next request addr=0x100.
- stall_in=1 for 3 cycles in FETCH with a hit -> inst_valid=0 and pc unchanged; release -> pulse with the held pc.
- rdy_in=0 mid-WAIT for 5 cycles with if_load_done=1 -> no fill, no state change; rdy_in=1 -> completes normally. rst_in=0 mid-miss -> request dropped, all valid bits 0, pc=RESET_PC.

Source files
------------

// File: rtl/if_fetch_icache_if.sv
// Fetch-side bus between the instruction-fetch stage and the memory controller IF port.
// The fetch stage is the master; it drives the request and the memory controller returns the word.
interface if_fetch_icache_if;
  logic        if_read_or_not;
  logic [31:0] intru_addr;
  logic        if_load_done;
  logic [31:0] mem_ctrl_instru_to_if;

  modport master (
    output if_read_or_not,
    output intru_addr,
    input  if_load_done,
    input  mem_ctrl_instru_to_if
  );

  modport slave (
    input  if_read_or_not,
    input  intru_addr,
    output if_load_done,
    output mem_ctrl_instru_to_if
  );
endinterface

// File: rtl/if_fetch_icache.sv
// Instruction-fetch stage with a direct-mapped, one-word-per-line instruction cache.
// Hits issue in one cycle; misses fetch a word from the memory controller, fill, then issue.
module if_fetch_icache #(
  parameter int unsigned INDEX_WIDTH = 8,
  parameter logic [31:0] RESET_PC    = 32'h0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     rdy_in,
  input  logic                     stall_in,
  input  logic                     jump_flag,
  input  logic [31:0]              jump_pc,
  if_fetch_icache_if.master        mem,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              inst_pc
);

  localparam int unsigned LINES = 1 << INDEX_WIDTH;
  localparam int unsigned TAG_W = 32 - INDEX_WIDTH - 2;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    REQ   = 2'd1,
    WAIT  = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [31:0]            pc_q, pc_d;
  logic [31:0]            addr_q, addr_d;
  logic [31:0]            inst_q, inst_d;
  logic [31:0]            inst_pc_q, inst_pc_d;
  logic                   req_q, req_d;
  logic                   vld_q, vld_d;
  logic                   discard_q, discard_d;
  logic [LINES-1:0]       valid_q;
  logic [TAG_W-1:0]       tag_mem  [LINES];
  logic [31:0]            data_mem [LINES];

  logic [INDEX_WIDTH-1:0] pc_idx, fill_idx;
  logic [TAG_W-1:0]       pc_tag, fill_tag;
  logic [31:0]            jump_tgt;
  logic                   hit;
  logic                   fill;

  assign jump_tgt = jump_pc & 32'hFFFF_FFFC;
  assign pc_idx   = pc_q[INDEX_WIDTH+1:2];
  assign pc_tag   = pc_q[31:INDEX_WIDTH+2];
  assign fill_idx = addr_q[INDEX_WIDTH+1:2];
  assign fill_tag = addr_q[31:INDEX_WIDTH+2];
  assign hit      = valid_q[pc_idx] && (tag_mem[pc_idx] == pc_tag);
  // REQ never completes: if_load_done may still be high from the previous transfer.
  assign fill     = (state_q == WAIT) && mem.if_load_done;

  // State register
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= FETCH;
    end else if (rdy_in) begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      FETCH:   if (!jump_flag && !stall_in && !hit) state_d = REQ;
      REQ:     state_d = WAIT;
      WAIT:    if (mem.if_load_done) state_d = FETCH;
      default: state_d = FETCH;
    endcase
  end

  // Output / datapath next-state logic
  always_comb begin
    pc_d      = pc_q;
    addr_d    = addr_q;
    req_d     = req_q;
    vld_d     = 1'b0;
    inst_d    = inst_q;
    inst_pc_d = inst_pc_q;
    discard_d = discard_q;
    case (state_q)
      FETCH: begin
        if (jump_flag) begin
          pc_d = jump_tgt;
        end else if (!stall_in) begin
          if (hit) begin
            inst_d    = data_mem[pc_idx];
            inst_pc_d = pc_q;
            vld_d     = 1'b1;
            pc_d      = pc_q + 32'd4;
          end else begin
            req_d  = 1'b1;
            addr_d = pc_q;
          end
        end
      end
      REQ, WAIT: begin
        // A redirect never cancels the transfer; it only suppresses issuing the word.
        if (jump_flag) begin
          pc_d      = jump_tgt;
          discard_d = 1'b1;
        end
        if (fill) begin
          req_d     = 1'b0;
          discard_d = 1'b0;
          if (!discard_q && !jump_flag) begin
            vld_d     = 1'b1;
            inst_d    = mem.mem_ctrl_instru_to_if;
            inst_pc_d = addr_q;
            pc_d      = addr_q + 32'd4;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      pc_q      <= RESET_PC;
      addr_q    <= 32'h0;
      req_q     <= 1'b0;
      vld_q     <= 1'b0;
      inst_q    <= 32'h0;
      inst_pc_q <= 32'h0;
      discard_q <= 1'b0;
      valid_q   <= '0;
    end else if (rdy_in) begin
      pc_q      <= pc_d;
      addr_q    <= addr_d;
      req_q     <= req_d;
      vld_q     <= vld_d;
      inst_q    <= inst_d;
      inst_pc_q <= inst_pc_d;
      discard_q <= discard_d;
      if (fill) valid_q[fill_idx] <= 1'b1;
    end
  end

  // Tag/data arrays carry no reset; the valid bits gate every use.
  always_ff @(posedge clk_in) begin
    if (rdy_in && fill) begin
      tag_mem[fill_idx]  <= fill_tag;
      data_mem[fill_idx] <= mem.mem_ctrl_instru_to_if;
    end
  end

  assign mem.if_read_or_not = req_q;
  assign mem.intru_addr     = addr_q;
  assign inst_valid         = vld_q;
  assign inst               = inst_q;
  assign inst_pc            = inst_pc_q;

endmodule

// File: tb/tb_if_fetch_icache.sv
// Directed bench for if_fetch_icache: the bench plays the memory controller and back end,
// and a monitor pops the expected (pc, inst) pairs whenever inst_valid is seen.
module tb_if_fetch_icache;

  logic        clk = 1'b0;
  logic        rst_in;
  logic        rdy_in;
  logic        stall_in;
  logic        jump_flag;
  logic [31:0] jump_pc;
  logic        inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_pc;

  if_fetch_icache_if mbus();

  if_fetch_icache dut (
    .clk_in     (clk),
    .rst_in     (rst_in),
    .rdy_in     (rdy_in),
    .stall_in   (stall_in),
    .jump_flag  (jump_flag),
    .jump_pc    (jump_pc),
    .mem        (mbus),
    .inst_valid (inst_valid),
    .inst       (inst),
    .inst_pc    (inst_pc)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] data;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   checks   = 0;
  int   failures = 0;

  localparam logic [31:0] D0   = 32'h00500093;
  localparam logic [31:0] D4   = 32'h00100113;
  localparam logic [31:0] D8   = 32'h00200193;
  localparam logic [31:0] DC   = 32'h00300213;
  localparam logic [31:0] D10  = 32'h00400293;
  localparam logic [31:0] D14  = 32'h00600313;
  localparam logic [31:0] D18  = 32'h00700393;
  localparam logic [31:0] D1C  = 32'h00B00593;
  localparam logic [31:0] D20  = 32'h00800413;
  localparam logic [31:0] D24  = 32'h00C00613;
  localparam logic [31:0] D28  = 32'h00D00693;
  localparam logic [31:0] D100 = 32'h00900493;
  localparam logic [31:0] D104 = 32'h00A00513;
  localparam logic [31:0] DN0  = 32'hDEADBEEF;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic push(input logic [31:0] pc, input logic [31:0] data);
    exp_t e;
    e.pc   = pc;
    e.data = data;
    exp_q.push_back(e);
  endtask

  // Monitor: every inst_valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (inst_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse actual pc=%h inst=%h required no pulse", inst_pc, inst);
      end else begin
        mon_e = exp_q.pop_front();
        chk("pulse_pc", inst_pc, mon_e.pc);
        chk("pulse_inst", inst, mon_e.data);
      end
    end
  end

  task automatic wait_req(input logic [31:0] a);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (mbus.if_read_or_not !== 1'b1 && n < 40);
    chk("req_seen", {31'd0, mbus.if_read_or_not}, 32'd1);
    chk("req_addr", mbus.intru_addr, a);
  endtask

  // mode 0: plain fill; 1: redirect while waiting; 2: redirect on the completion cycle.
  task automatic serve(input logic [31:0] addr, input logic [31:0] data, input int gap,
                       input int mode, input logic [31:0] jpc, input bit stale, input bit stl);
    wait_req(addr);
    if (stl) stall_in = 1'b1;
    if (stale) begin
      mbus.if_load_done          = 1'b1;
      mbus.mem_ctrl_instru_to_if = 32'hBAD0BAD0;
    end
    @(posedge clk); #1;
    mbus.if_load_done = 1'b0;
    if (mode == 1) begin
      jump_flag = 1'b1;
      jump_pc   = jpc;
      @(posedge clk); #1;
      jump_flag = 1'b0;
    end
    repeat (gap) begin
      @(negedge clk);
      chk("req_hold", {31'd0, mbus.if_read_or_not}, 32'd1);
      chk("addr_hold", mbus.intru_addr, addr);
      @(posedge clk); #1;
    end
    mbus.if_load_done          = 1'b1;
    mbus.mem_ctrl_instru_to_if = data;
    if (mode == 2) begin
      jump_flag = 1'b1;
      jump_pc   = jpc;
    end
    @(posedge clk); #1;
    mbus.if_load_done = 1'b0;
    jump_flag         = 1'b0;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_req", {31'd0, mbus.if_read_or_not}, 32'd0);
    chk("rst_addr", mbus.intru_addr, 32'd0);
    chk("rst_vld", {31'd0, inst_valid}, 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_inst_pc", inst_pc, 32'd0);
  endtask

  initial begin
    rst_in = 1'b0;
    rdy_in = 1'b1;
    stall_in = 1'b0;
    jump_flag = 1'b0;
    jump_pc = 32'h0;
    mbus.if_load_done = 1'b0;
    mbus.mem_ctrl_instru_to_if = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst_in = 1'b1;

    // Cold miss at 0, then sequential fills.
    push(32'h0, D0);
    serve(32'h0, D0, 2, 0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    chk("cold_vld", {31'd0, inst_valid}, 32'd1);
    chk("cold_pc", inst_pc, 32'h0);
    push(32'h4, D4);  serve(32'h4, D4, 0, 0, 32'h0, 1'b0, 1'b0);
    push(32'h8, D8);  serve(32'h8, D8, 3, 0, 32'h0, 1'b0, 1'b0);
    push(32'hC, DC);  serve(32'hC, DC, 1, 0, 32'h0, 1'b0, 1'b0);

    // Redirect back to 0 while 0x10 is outstanding, then five back-to-back hits.
    serve(32'h10, D10, 1, 1, 32'h0, 1'b0, 1'b0);
    push(32'h0, D0); push(32'h4, D4); push(32'h8, D8); push(32'hC, DC); push(32'h10, D10);
    @(negedge clk);
    chk("discard_no_pulse", {31'd0, inst_valid}, 32'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("b2b_vld", {31'd0, inst_valid}, 32'd1);
      chk("b2b_noreq", {31'd0, mbus.if_read_or_not}, 32'd0);
    end

    // Stale if_load_done during REQ must be ignored.
    push(32'h14, D14);
    serve(32'h14, D14, 2, 0, 32'h0, 1'b1, 1'b0);

    // Redirect on the completion cycle: fill, no output, pc = 0x20.
    serve(32'h18, D18, 1, 2, 32'h20, 1'b0, 1'b0);

    // Redirect to 0x100 while waiting for 0x20.
    serve(32'h20, D20, 2, 1, 32'h100, 1'b0, 1'b0);
    push(32'h100, D100);
    serve(32'h100, D100, 0, 0, 32'h0, 1'b0, 1'b0);

    // Return to 0x20: must hit without a request.
    serve(32'h104, D104, 0, 1, 32'h20, 1'b0, 1'b0);
    push(32'h20, D20);
    @(negedge clk);
    chk("redir_no_pulse", {31'd0, inst_valid}, 32'd0);
    @(negedge clk);
    chk("refill_hit_vld", {31'd0, inst_valid}, 32'd1);
    chk("refill_hit_noreq", {31'd0, mbus.if_read_or_not}, 32'd0);

    // Stall in FETCH on a hit at 0 for three cycles.
    serve(32'h24, D24, 1, 1, 32'h0, 1'b0, 1'b0);
    stall_in = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("stall_vld", {31'd0, inst_valid}, 32'd0);
      chk("stall_noreq", {31'd0, mbus.if_read_or_not}, 32'd0);
    end
    stall_in = 1'b0;
    push(32'h0, D0); push(32'h4, D4); push(32'h8, D8); push(32'hC, DC);
    push(32'h10, D10); push(32'h14, D14); push(32'h18, D18);

    // Stall while a miss completes: word still presented, then held.
    push(32'h1C, D1C);
    serve(32'h1C, D1C, 1, 0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    chk("stall_fill_vld", {31'd0, inst_valid}, 32'd1);
    repeat (2) begin
      @(negedge clk);
      chk("stall_after_fill", {31'd0, inst_valid}, 32'd0);
    end
    stall_in = 1'b0;
    push(32'h20, D20); push(32'h24, D24);

    // Global freeze mid-WAIT with if_load_done high.
    wait_req(32'h28);
    @(posedge clk); #1;
    rdy_in = 1'b0;
    mbus.if_load_done = 1'b1;
    mbus.mem_ctrl_instru_to_if = D28;
    repeat (5) begin
      @(negedge clk);
      chk("frz_req", {31'd0, mbus.if_read_or_not}, 32'd1);
      chk("frz_vld", {31'd0, inst_valid}, 32'd0);
    end
    rdy_in = 1'b1;
    push(32'h28, D28);
    @(posedge clk); #1;
    mbus.if_load_done = 1'b0;

    // Reset in the middle of a miss.
    wait_req(32'h2C);
    @(posedge clk); #1;
    rst_in = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk_reset_outputs();
    @(posedge clk); #1;
    rst_in = 1'b1;
    push(32'h0, DN0);
    serve(32'h0, DN0, 1, 0, 32'h0, 1'b0, 1'b0);
    wait_req(32'h4);
    repeat (3) @(negedge clk);
    chk("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
